// File: rtl/pixel_write_ctrl.sv
// rtl/pixel_write_ctrl.sv - pixel stream consumer: FIFO, clip, linear address, SRAM write
//
// Purpose: buffers {X,Y} pixel addresses from the primitive generators together with the
// colour sampled at push, discards off-screen points, writes in-range points to the
// framebuffer SRAM through a req/ack port and pulses write_done once a primitive is committed.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   pix_addr[18:0]        {X[9:0], Y[8:0]} pixel address
//   pix_valid/pix_ready   pixel handshake, transfer when both high
//   prim_done             1-cycle pulse, generator emitted its last pixel
//   color[COLOR_W-1:0]    pixel colour, captured with the pixel
//   mem_req/mem_ack       SRAM write handshake, req held until ack
//   mem_addr, mem_wdata   registered SRAM write address (Y*H_RES+X) and data
//   write_done            1-cycle pulse, primitive fully committed
//   clip_cnt[15:0]        saturating count of clipped pixels
module pixel_write_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [18:0]        pix_addr,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               prim_done,
  input  logic [COLOR_W-1:0] color,
  output logic               mem_req,
  output logic [18:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               write_done,
  output logic [15:0]        clip_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 19 + COLOR_W;
  localparam logic [10:0] H_LIM  = 11'(H_RES);
  localparam logic [9:0]  V_LIM  = 10'(V_RES);
  localparam logic [18:0] H_MULT = 19'(H_RES);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t             state;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               ready_en;
  logic               done_pending;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   head;
  logic [9:0]         head_x;
  logic [8:0]         head_y;
  logic [COLOR_W-1:0] head_c;
  logic               clipped;
  logic [18:0]        lin_addr;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // ready_en keeps pix_ready low while reset is held and releases it on the first clock after.
  assign pix_ready = ready_en & ~full;
  assign push  = pix_valid & pix_ready;
  assign pop   = (state == LOAD) & ~empty;

  assign head     = fifo_mem[rd_ptr];
  assign head_x   = head[ENT_W-1 -: 10];
  assign head_y   = head[COLOR_W +: 9];
  assign head_c   = head[COLOR_W-1:0];
  // Negative generator coordinates wrap to large unsigned values and fall out here too.
  assign clipped  = ({1'b0, head_x} >= H_LIM) || ({1'b0, head_y} >= V_LIM);
  assign lin_addr = 19'(head_y) * H_MULT + 19'(head_x);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_addr, color};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      write_done   <= 1'b0;
      clip_cnt     <= '0;
      done_pending <= 1'b0;
    end else begin
      write_done <= 1'b0;
      case (state)
        IDLE: begin
          if (done_pending && empty) begin
            state        <= DONE;
            write_done   <= 1'b1;
            done_pending <= 1'b0;
          end else if (!empty) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (empty) begin
            state <= IDLE;
          end else if (clipped) begin
            if (clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
            // Fall back to IDLE when the clipped entry was the last one so the
            // completion check gets a chance to run.
            if (count == CNT_ONE) state <= IDLE;
          end else begin
            mem_addr  <= lin_addr;
            mem_wdata <= head_c;
            mem_req   <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= empty ? IDLE : LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // A new prim_done wins over the clear in IDLE so a back-to-back primitive is not lost.
      if (prim_done) done_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// tb/tb_pixel_write_ctrl.sv - self-checking bench for pixel_write_ctrl
module tb_pixel_write_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [18:0] pix_addr = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        prim_done = 1'b0;
  logic [7:0]  color = '0;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic        write_done;
  logic [15:0] clip_cnt;

  always #5 clk = ~clk;

  pixel_write_ctrl #(.FIFO_DEPTH(4), .COLOR_W(8), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .n_rst(n_rst), .pix_addr(pix_addr), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .prim_done(prim_done), .color(color), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .write_done(write_done), .clip_cnt(clip_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [26:0] writes[$];
  logic [26:0] exp_q[$];
  int exp_clip = 0;
  int done_cnt = 0;
  int done_target = 0;
  int wr_at_done = 0;

  int ack_delay = 0;
  bit ack_rand = 0;
  bit spurious_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SRAM responder: acks after a programmable delay and logs every accepted write.
  int wait_cnt = 0;
  int cur_delay = 0;
  logic [26:0] req_word;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt == 0) begin
        cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
        req_word  = {mem_addr, mem_wdata};
      end else begin
        check("req_stable", {5'd0, mem_addr, mem_wdata}, {5'd0, req_word});
      end
      if (wait_cnt >= cur_delay) begin
        mem_ack = 1'b1;
        writes.push_back({mem_addr, mem_wdata});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spurious_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
    end
  end

  logic prev_wd = 1'b0;
  always @(negedge clk) begin
    if (write_done) begin
      done_cnt++;
      wr_at_done = writes.size();
      check("done_pulse_width", {31'd0, prev_wd}, 32'd0);
    end
    prev_wd = write_done;
  end

  // Reference model: every accepted in-range pixel becomes one write Y*640+X in push order.
  task automatic push(input int x, input int y, input logic [7:0] c, input bit pd, output bit waited);
    int t = 0;
    waited = 0;
    pix_addr = {10'(x), 9'(y)};
    color = c;
    pix_valid = 1'b1;
    while (!pix_ready && t < 300) begin
      waited = 1;
      tick();
      t++;
    end
    if (!pix_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      pix_valid = 1'b0;
    end else begin
      prim_done = pd;
      tick();
      pix_valid = 1'b0;
      prim_done = 1'b0;
      if (x < 640 && y < 480) exp_q.push_back({19'(y * 640 + x), c});
      else exp_clip++;
    end
  endtask

  task automatic wait_done(input string name, input int target);
    int t = 0;
    while (done_cnt < target && t < 1000) begin
      tick();
      t++;
    end
    check(name, done_cnt, target);
  endtask

  task automatic compare_writes(input string name);
    int n;
    check({name, "_count"}, writes.size(), exp_q.size());
    n = (writes.size() < exp_q.size()) ? writes.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_word"}, {5'd0, writes[i]}, {5'd0, exp_q[i]});
    writes.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [7:0] c;
    bit         wr;
    int         addr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit w;
    int first_stall;
    int lat;
    int wsz;
    int dsz;
    int cb;
    int xs[8];
    int ys[8];

    tbl[0] = '{100, 50,  8'hA5, 1'b1, 32100};
    tbl[1] = '{1023, 10, 8'h01, 1'b0, 0};
    tbl[2] = '{639, 479, 8'h3C, 1'b1, 307199};
    tbl[3] = '{5,   480, 8'h02, 1'b0, 0};
    tbl[4] = '{0,   0,   8'h11, 1'b1, 0};
    tbl[5] = '{639, 0,   8'h22, 1'b1, 639};
    tbl[6] = '{0,   479, 8'h33, 1'b1, 306560};
    tbl[7] = '{640, 0,   8'h44, 1'b0, 0};

    // Reset state
    tick(); tick();
    check("rst_pix_ready", {31'd0, pix_ready}, 0);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_mem_addr", {13'd0, mem_addr}, 0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    check("rst_write_done", {31'd0, write_done}, 0);
    check("rst_clip_cnt", {16'd0, clip_cnt}, 0);
    n_rst = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, pix_ready}, 1);

    // Table: one pixel per primitive, zero-wait ack
    for (int i = 0; i < 8; i++) begin
      wsz = writes.size();
      cb = exp_clip;
      push(tbl[i].x, tbl[i].y, tbl[i].c, 1'b1, w);
      done_target++;
      wait_done("tbl_done", done_target);
      if (tbl[i].wr) begin
        check("tbl_write_count", writes.size(), wsz + 1);
        if (writes.size() > wsz) begin
          check("tbl_addr", {13'd0, writes[wsz][26:8]}, tbl[i].addr);
          check("tbl_data", {24'd0, writes[wsz][7:0]}, {24'd0, tbl[i].c});
        end
      end else begin
        check("tbl_write_count", writes.size(), wsz);
      end
      check("tbl_clip_cnt", {16'd0, clip_cnt}, cb + (tbl[i].wr ? 0 : 1));
    end
    writes.delete();
    exp_q.delete();

    // Back-to-back clip sequence
    cb = exp_clip;
    push(1023, 10, 8'h5A, 1'b0, w);
    push(639, 479, 8'h6B, 1'b0, w);
    push(5, 480, 8'h7C, 1'b1, w);
    done_target++;
    wait_done("clipseq_done", done_target);
    check("clipseq_count", writes.size(), 1);
    if (writes.size() > 0) check("clipseq_addr", {13'd0, writes[0][26:8]}, 307199);
    check("clipseq_clip", {16'd0, clip_cnt}, cb + 2);
    compare_writes("clipseq");

    // Backpressure: slow ack, continuous stream of 8
    tick(); tick(); tick();
    ack_delay = 5;
    first_stall = -1;
    for (int i = 0; i < 8; i++) begin
      push(i * 10 + 1, i + 3, 8'h40 + 8'(i), i == 7, w);
      if (w && first_stall < 0) first_stall = i;
    end
    check("bp_first_stall", first_stall, 5);
    done_target++;
    wait_done("bp_done", done_target);
    compare_writes("bp");

    // Circle octant points, radius (3,1) around (320,240)
    ack_delay = 1;
    xs = '{323, 317, 323, 317, 321, 319, 321, 319};
    ys = '{241, 241, 239, 239, 243, 243, 237, 237};
    for (int i = 0; i < 8; i++) push(xs[i], ys[i], 8'hC0 + 8'(i), i == 7, w);
    done_target++;
    wait_done("circ_done", done_target);
    check("circ_writes_at_done", wr_at_done, 8);
    compare_writes("circ");

    // prim_done together with the last push
    ack_delay = 0;
    push(10, 20, 8'h01, 1'b0, w);
    push(11, 21, 8'h02, 1'b0, w);
    push(12, 22, 8'h03, 1'b1, w);
    done_target++;
    wait_done("last_push_done", done_target);
    check("last_push_writes_at_done", wr_at_done, 3);
    compare_writes("last_push");

    // prim_done with empty FIFO and idle FSM
    tick(); tick(); tick();
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    lat = 1;
    while (!write_done && lat < 10) begin
      tick();
      lat++;
    end
    check("empty_done_latency", lat, 2);
    tick(); tick(); tick();
    done_target++;
    check("empty_done_once", done_cnt, done_target);

    // Merged prim_done pulses during a pending primitive
    ack_delay = 8;
    push(50, 60, 8'h99, 1'b1, w);
    prim_done = 1'b1; tick(); prim_done = 1'b0; tick();
    prim_done = 1'b1; tick(); prim_done = 1'b0;
    done_target++;
    wait_done("merge_done", done_target);
    for (int i = 0; i < 20; i++) tick();
    check("merge_once", done_cnt, done_target);
    compare_writes("merge");

    // Randomized stream with random ack latency and stray acks
    ack_rand = 1;
    spurious_en = 1;
    for (int i = 0; i < 60; i++) begin
      int x;
      int y;
      x = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(0, 1023));
      y = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 511));
      push(x, y, 8'($urandom), i == 59, w);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end
    done_target++;
    wait_done("rand_done", done_target);
    compare_writes("rand");
    check("rand_clip_cnt", {16'd0, clip_cnt}, exp_clip);
    ack_rand = 0;
    spurious_en = 0;

    // Reset in the middle of a write with queued pixels
    ack_delay = 20;
    push(1000, 1, 8'h0F, 1'b0, w);
    push(1, 1, 8'h10, 1'b0, w);
    push(2, 2, 8'h20, 1'b0, w);
    push(3, 3, 8'h30, 1'b0, w);
    push(4, 4, 8'h40, 1'b1, w);
    lat = 0;
    while (!mem_req && lat < 50) begin
      tick();
      lat++;
    end
    check("rst_reached_write", {31'd0, mem_req}, 1);
    n_rst = 1'b0;
    #1;
    check("rst_async_req", {31'd0, mem_req}, 0);
    check("rst_async_done", {31'd0, write_done}, 0);
    check("rst_async_clip", {16'd0, clip_cnt}, 0);
    check("rst_async_ready", {31'd0, pix_ready}, 0);
    tick(); tick();
    n_rst = 1'b1;
    wsz = writes.size();
    dsz = done_cnt;
    for (int i = 0; i < 30; i++) tick();
    check("rst_no_writes", writes.size(), wsz);
    check("rst_no_done", done_cnt, dsz);
    check("rst_ready_after", {31'd0, pix_ready}, 1);
    ack_delay = 0;
    push(7, 7, 8'h77, 1'b1, w);
    wait_done("rst_fresh_done", dsz + 1);
    check("rst_fresh_count", writes.size(), wsz + 1);
    if (writes.size() > wsz) check("rst_fresh_word", {5'd0, writes[wsz]}, {5'd0, 19'(7 * 640 + 7), 8'h77});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
